// File: rtl/io_map_pkg.sv
// Shared constants for the board I/O bridge: register offsets, CTRL layout
// and the hex-to-segment font.
package io_map_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OFF_W  = 3;
  localparam int unsigned SEG_W  = 8;

  // Word offsets inside the 32-byte window (mem_addr[4:2])
  localparam logic [OFF_W-1:0] OFF_LED  = 3'd0;
  localparam logic [OFF_W-1:0] OFF_SW   = 3'd1;
  localparam logic [OFF_W-1:0] OFF_SEG  = 3'd2;
  localparam logic [OFF_W-1:0] OFF_CTRL = 3'd3;
  localparam logic [OFF_W-1:0] OFF_EDGE = 3'd4;

  localparam int unsigned CTRL_BLANK_W = 8;
  localparam int unsigned CTRL_EN_BIT  = 8;
  localparam int unsigned CTRL_W       = 9;

  typedef struct packed {
    logic                    en;
    logic [CTRL_BLANK_W-1:0] blank;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{en: 1'b1, blank: 8'h00};

  // Active-low {dp,g..a}; dp is always off
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] on;
    case (nib)
      4'h0: on = 7'h3F;
      4'h1: on = 7'h06;
      4'h2: on = 7'h5B;
      4'h3: on = 7'h4F;
      4'h4: on = 7'h66;
      4'h5: on = 7'h6D;
      4'h6: on = 7'h7D;
      4'h7: on = 7'h07;
      4'h8: on = 7'h7F;
      4'h9: on = 7'h6F;
      4'hA: on = 7'h77;
      4'hB: on = 7'h7C;
      4'hC: on = 7'h39;
      4'hD: on = 7'h5E;
      4'hE: on = 7'h79;
      default: on = 7'h71;
    endcase
    return {1'b1, ~on};
  endfunction

endpackage

// File: rtl/seg_scan.sv
// Time-multiplexed 7-segment driver: slot divider, digit index, font lookup
// and active-low enable decode. seg_led_o/seg_en_o are registered together.
module seg_scan
  import io_map_pkg::*;
#(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   seg_val_i,
  input  logic [DIGITS-1:0]     blank_i,
  input  logic                  disp_en_i,
  output logic [SEG_W-1:0]      seg_led_o,
  output logic [DIGITS-1:0]     seg_en_o
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [SEG_W-1:0]  seg_led_q, seg_led_d;
  logic [DIGITS-1:0] seg_en_q, seg_en_d;
  logic              slot_end_c;
  logic [3:0]        nib_c;

  always_comb begin
    div_d      = div_q;
    idx_d      = idx_q;
    nib_c      = 4'h0;
    seg_en_d   = '1;
    slot_end_c = (div_q == DIV_W'(SCAN_DIV - 1));

    if (slot_end_c) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    // Select the nibble and the enable bit for the digit currently in its slot
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_c = seg_val_i[4*i +: 4];
        if (disp_en_i && !blank_i[i]) begin
          seg_en_d[i] = 1'b0;
        end
      end
    end

    seg_led_d = hex_to_seg(nib_c);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q     <= '0;
      idx_q     <= '0;
      seg_led_q <= '1;
      seg_en_q  <= '1;
    end else begin
      div_q     <= div_d;
      idx_q     <= idx_d;
      seg_led_q <= seg_led_d;
      seg_en_q  <= seg_en_d;
    end
  end

  assign seg_led_o = seg_led_q;
  assign seg_en_o  = seg_en_q;

endmodule

// File: rtl/io_mmio_bridge.sv
// Memory-mapped bridge from the CPU data bus to switches, LEDs and the
// multiplexed 7-segment display, with debounced switches and W1C edge flags.
module io_mmio_bridge
  import io_map_pkg::*;
#(
  parameter int unsigned       SW_WIDTH     = 24,
  parameter int unsigned       LED_WIDTH    = 24,
  parameter int unsigned       DIGITS       = 8,
  parameter int unsigned       SCAN_DIV     = 100000,
  parameter int unsigned       DEBOUNCE_DIV = 500000,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 32'hFFFFFC00
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic                 mem_wen,
  input  logic                 mem_ren,
  input  logic [DATA_W-1:0]    mem_wdata,
  output logic                 io_hit,
  output logic [DATA_W-1:0]    mem_rdata,
  input  logic [SW_WIDTH-1:0]  switch_in,
  output logic [LED_WIDTH-1:0] led_out,
  output logic [SEG_W-1:0]     seg_led,
  output logic [DIGITS-1:0]    seg_en
);

  localparam int unsigned DEB_W = (DEBOUNCE_DIV > 1) ? $clog2(DEBOUNCE_DIV) : 1;

  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [DATA_W-1:0]    seg_q, seg_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic [SW_WIDTH-1:0]  edge_q, edge_d;
  logic [SW_WIDTH-1:0]  sync1_q, sync2_q;
  logic [SW_WIDTH-1:0]  samp_q, samp_d;
  logic [SW_WIDTH-1:0]  sw_q, sw_d;
  logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;

  logic [OFF_W-1:0]     reg_sel_c;
  logic                 wr_c;
  logic                 rd_c;
  logic                 tick_c;
  logic [SW_WIDTH-1:0]  agree_c;
  logic [SW_WIDTH-1:0]  rise_c;
  logic [SW_WIDTH-1:0]  edge_clr_c;
  logic [DATA_W-1:0]    rdata_c;
  logic [1:0]           unused_addr_c;

  assign io_hit        = (mem_addr[ADDR_W-1:5] == BASE_ADDR[ADDR_W-1:5]);
  assign reg_sel_c     = mem_addr[4:2];
  assign unused_addr_c = mem_addr[1:0];

  // Read mux: unmapped offsets return zero
  always_comb begin
    rdata_c = '0;
    case (reg_sel_c)
      OFF_LED:  rdata_c = DATA_W'(led_q);
      OFF_SW:   rdata_c = DATA_W'(sw_q);
      OFF_SEG:  rdata_c = seg_q;
      OFF_CTRL: rdata_c = {{(DATA_W - CTRL_W){1'b0}}, ctrl_q};
      OFF_EDGE: rdata_c = DATA_W'(edge_q);
      default:  rdata_c = '0;
    endcase
  end

  always_comb begin
    wr_c       = mem_wen && io_hit;
    rd_c       = mem_ren && io_hit;
    led_d      = led_q;
    seg_d      = seg_q;
    ctrl_d     = ctrl_q;
    edge_clr_c = '0;

    if (wr_c) begin
      case (reg_sel_c)
        OFF_LED:  led_d      = mem_wdata[LED_WIDTH-1:0];
        OFF_SEG:  seg_d      = mem_wdata;
        OFF_CTRL: ctrl_d     = ctrl_t'(mem_wdata[CTRL_W-1:0]);
        OFF_EDGE: edge_clr_c = mem_wdata[SW_WIDTH-1:0];
        default:  ;
      endcase
    end

    // Sample on each tick; accept a bit only when two consecutive samples agree
    tick_c    = (deb_cnt_q == DEB_W'(DEBOUNCE_DIV - 1));
    deb_cnt_d = tick_c ? '0 : deb_cnt_q + DEB_W'(1);
    samp_d    = tick_c ? sync2_q : samp_q;
    agree_c   = ~(sync2_q ^ samp_q);
    sw_d      = tick_c ? ((agree_c & sync2_q) | (~agree_c & sw_q)) : sw_q;
    rise_c    = sw_d & ~sw_q;

    // A rise in the same cycle as a clear keeps the flag set
    edge_d  = (edge_q & ~edge_clr_c) | rise_c;
    rdata_d = rd_c ? rdata_c : rdata_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q     <= '0;
      seg_q     <= '0;
      ctrl_q    <= CTRL_RST;
      edge_q    <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      samp_q    <= '0;
      sw_q      <= '0;
      deb_cnt_q <= '0;
      rdata_q   <= '0;
    end else begin
      led_q     <= led_d;
      seg_q     <= seg_d;
      ctrl_q    <= ctrl_d;
      edge_q    <= edge_d;
      sync1_q   <= switch_in;
      sync2_q   <= sync1_q;
      samp_q    <= samp_d;
      sw_q      <= sw_d;
      deb_cnt_q <= deb_cnt_d;
      rdata_q   <= rdata_d;
    end
  end

  seg_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .clock     (clock),
    .reset     (reset),
    .seg_val_i (seg_q[4*DIGITS-1:0]),
    .blank_i   (ctrl_q.blank[DIGITS-1:0]),
    .disp_en_i (ctrl_q.en),
    .seg_led_o (seg_led),
    .seg_en_o  (seg_en)
  );

  assign led_out   = led_q;
  assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_io_mmio_bridge.sv
// Self-checking bench for io_mmio_bridge with short scan/debounce dividers.
module tb_io_mmio_bridge;

  localparam logic [31:0] BASE = 32'hFFFFFC00;
  localparam logic [31:0] A_LED  = BASE + 32'h00;
  localparam logic [31:0] A_SW   = BASE + 32'h04;
  localparam logic [31:0] A_SEG  = BASE + 32'h08;
  localparam logic [31:0] A_CTRL = BASE + 32'h0C;
  localparam logic [31:0] A_EDGE = BASE + 32'h10;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic        mem_ren;
  logic [31:0] mem_wdata;
  logic        io_hit;
  logic [31:0] mem_rdata;
  logic [23:0] switch_in;
  logic [23:0] led_out;
  logic [7:0]  seg_led;
  logic [7:0]  seg_en;

  io_mmio_bridge #(
    .SW_WIDTH     (24),
    .LED_WIDTH    (24),
    .DIGITS       (8),
    .SCAN_DIV     (4),
    .DEBOUNCE_DIV (4),
    .BASE_ADDR    (BASE)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .mem_addr  (mem_addr),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_wdata (mem_wdata),
    .io_hit    (io_hit),
    .mem_rdata (mem_rdata),
    .switch_in (switch_in),
    .led_out   (led_out),
    .seg_led   (seg_led),
    .seg_en    (seg_en)
  );

  always #5 clock = ~clock;

  int ecnt = 0;
  always @(posedge clock) ecnt <= ecnt + 1;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] ra;
    logic [31:0] exp_rd;
    logic [23:0] exp_led;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", nm, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    mem_addr  = a;
    mem_wdata = d;
    mem_wen   = 1'b1;
    step();
    mem_wen   = 1'b0;
  endtask

  task automatic raw_read(input logic [31:0] a, output logic [31:0] d);
    mem_addr = a;
    mem_ren  = 1'b1;
    step();
    mem_ren  = 1'b0;
    d        = mem_rdata;
  endtask

  task automatic bus_read_chk(input logic [31:0] a, input logic [31:0] e, input string nm);
    logic [31:0] got;
    exp_q.push_back(e);
    name_q.push_back(nm);
    raw_read(a, got);
    check(name_q.pop_front(), got, exp_q.pop_front());
  endtask

  function automatic logic [7:0] exp_seg(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'h3F;  4'h1: f = 7'h06;  4'h2: f = 7'h5B;  4'h3: f = 7'h4F;
      4'h4: f = 7'h66;  4'h5: f = 7'h6D;  4'h6: f = 7'h7D;  4'h7: f = 7'h07;
      4'h8: f = 7'h7F;  4'h9: f = 7'h6F;  4'hA: f = 7'h77;  4'hB: f = 7'h7C;
      4'hC: f = 7'h39;  4'hD: f = 7'h5E;  4'hE: f = 7'h79;  default: f = 7'h71;
    endcase
    return {1'b1, ~f};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] found;
    logic [31:0] segv;
    logic [7:0]  prev;
    logic [7:0]  ee;
    int          d;
    int          cnt;
    int          fall_e;
    int          x;

    vecs[0] = '{A_LED,            32'h00ABCDEF, A_LED,           32'h00ABCDEF, 24'hABCDEF};
    vecs[1] = '{A_LED,            32'hFFFFFFFF, BASE + 32'h3,    32'h00FFFFFF, 24'hFFFFFF};
    vecs[2] = '{BASE + 32'h20,    32'h00000012, A_LED,           32'h00FFFFFF, 24'hFFFFFF};
    vecs[3] = '{A_SEG,            32'h12345678, A_SEG,           32'h12345678, 24'hFFFFFF};
    vecs[4] = '{A_CTRL,           32'hFFFFFFFF, A_CTRL,          32'h000001FF, 24'hFFFFFF};
    vecs[5] = '{A_CTRL,           32'h00000100, A_CTRL,          32'h00000100, 24'hFFFFFF};
    vecs[6] = '{BASE + 32'h14,    32'h0000DEAD, BASE + 32'h14,   32'h00000000, 24'hFFFFFF};
    vecs[7] = '{BASE + 32'h1C,    32'h00000005, A_SW,            32'h00000000, 24'hFFFFFF};
    vecs[8] = '{A_LED,            32'h00ABCDEF, A_LED,           32'h00ABCDEF, 24'hABCDEF};

    reset     = 1'b1;
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    mem_wdata = '0;
    switch_in = '0;

    // Reset held several cycles: outputs stay at reset values
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_led_%0d", i), {8'h0, led_out}, 32'h0);
      check($sformatf("rst_en_%0d", i), {24'h0, seg_en}, 32'hFF);
      check($sformatf("rst_seg_%0d", i), {24'h0, seg_led}, 32'hFF);
      check($sformatf("rst_rdata_%0d", i), mem_rdata, 32'h0);
    end
    reset = 1'b0;
    bus_read_chk(A_CTRL, 32'h100, "ctrl_reset");

    mem_addr = BASE + 32'h1C; #1 check("hit_top", {31'h0, io_hit}, 32'h1);
    mem_addr = 32'hFFFFFBFC;  #1 check("hit_below", {31'h0, io_hit}, 32'h0);
    mem_addr = BASE + 32'h20; #1 check("hit_above", {31'h0, io_hit}, 32'h0);

    for (int i = 0; i < 9; i++) begin
      bus_write(vecs[i].wa, vecs[i].wd);
      check($sformatf("vec%0d_led", i), {8'h0, led_out}, {8'h0, vecs[i].exp_led});
      bus_read_chk(vecs[i].ra, vecs[i].exp_rd, $sformatf("vec%0d_rd", i));
    end

    // Read outside the window leaves mem_rdata untouched
    raw_read(32'h00001000, v);
    check("rd_miss_hold", v, 32'h00ABCDEF);

    // Same-cycle write and read of LED returns the old value
    mem_addr = A_LED; mem_wdata = 32'h00123456; mem_wen = 1'b1; mem_ren = 1'b1;
    step();
    mem_wen = 1'b0; mem_ren = 1'b0;
    check("wr_rd_old", mem_rdata, 32'h00ABCDEF);
    check("wr_rd_led", {8'h0, led_out}, 32'h00123456);
    bus_read_chk(A_LED, 32'h00123456, "wr_rd_new");

    // Scan: align to the start of digit 0's slot, then follow a full rotation
    segv  = 32'h12345678;
    prev  = seg_en;
    found = 0;
    for (int k = 0; k < 80 && found == 0; k++) begin
      step();
      if (seg_en == 8'hFE && prev != 8'hFE) found = 1;
      prev = seg_en;
    end
    check("scan_sync", found, 32'h1);
    for (int k = 0; k < 33; k++) begin
      d  = (k / 4) % 8;
      ee = ~(8'h01 << d);
      check($sformatf("scan_en_%0d", k), {24'h0, seg_en}, {24'h0, ee});
      check($sformatf("scan_seg_%0d", k), {24'h0, seg_led}, {24'h0, exp_seg(segv[4*d +: 4])});
      step();
    end

    // Blank digits 4..7: their enables never go low, 16 of 32 cycles fully dark
    bus_write(A_CTRL, 32'h1F0);
    step();
    step();
    cnt = 0;
    for (int k = 0; k < 32; k++) begin
      check($sformatf("blank_hi_%0d", k), {28'h0, seg_en[7:4]}, 32'hF);
      if (seg_en == 8'hFF) cnt++;
      step();
    end
    check("blank_dark_cycles", cnt, 32'd16);

    bus_write(A_CTRL, 32'h000);
    step();
    step();
    for (int k = 0; k < 16; k++) begin
      check($sformatf("disabled_%0d", k), {24'h0, seg_en}, 32'hFF);
      step();
    end

    // Bounce bit 3 at a 3-cycle period: no sample pair ever agrees on 1
    for (int p = 0; p < 8; p++) begin
      switch_in[3] = 1'b1; step();
      switch_in[3] = 1'b0; step();
      step();
    end
    bus_read_chk(A_SW, 32'h0, "bounce_sw");
    bus_read_chk(A_EDGE, 32'h0, "bounce_edge");

    switch_in[3] = 1'b1;
    found = 0;
    for (int k = 0; k < 12 && found == 0; k++) begin
      raw_read(A_SW, v);
      if (v[3]) found = 1;
    end
    check("sw3_rise_12", found, 32'h1);
    bus_read_chk(A_SW, 32'h8, "sw_after_hold");
    bus_read_chk(A_EDGE, 32'h8, "edge_after_hold");

    // Release the switch and note the tick edge on which SW fell
    switch_in[3] = 1'b0;
    found  = 0;
    fall_e = 0;
    for (int k = 0; k < 16 && found == 0; k++) begin
      raw_read(A_SW, v);
      if (!v[3]) begin
        found  = 1;
        fall_e = ecnt - 1;
      end
    end
    check("sw3_fall", found, 32'h1);
    bus_write(A_EDGE, 32'h8);
    bus_read_chk(A_EDGE, 32'h0, "edge_cleared");

    // Press so the debounced rise lands on the same edge as a W1C clear
    while (((ecnt - fall_e) % 4) != 1) step();
    x = ecnt;
    switch_in[3] = 1'b1;
    while (ecnt != x + 6) step();
    bus_write(A_EDGE, 32'h8);
    bus_read_chk(A_SW, 32'h8, "sw_at_collision");
    bus_read_chk(A_EDGE, 32'h8, "edge_set_wins");
    bus_write(A_EDGE, 32'h8);
    bus_read_chk(A_EDGE, 32'h0, "edge_next_clear");

    // Reset mid-operation with registers and display active
    bus_write(A_CTRL, 32'h100);
    bus_write(A_EDGE, 32'h0);
    step();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst2_led_%0d", i), {8'h0, led_out}, 32'h0);
      check($sformatf("rst2_en_%0d", i), {24'h0, seg_en}, 32'hFF);
      check($sformatf("rst2_seg_%0d", i), {24'h0, seg_led}, 32'hFF);
      check($sformatf("rst2_rdata_%0d", i), mem_rdata, 32'h0);
    end
    reset = 1'b0;
    bus_read_chk(A_SW, 32'h0, "rst2_sw");
    bus_read_chk(A_EDGE, 32'h0, "rst2_edge");
    bus_read_chk(A_LED, 32'h0, "rst2_led_rd");
    bus_read_chk(A_SEG, 32'h0, "rst2_seg_rd");
    bus_read_chk(A_CTRL, 32'h100, "rst2_ctrl_rd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
